// File: rtl/sound_latch_if.sv
// rtl/sound_latch_if.sv - command/reply mailbox between main and sound 68000s with sound-CPU IRQ
module sound_latch_if #(
  parameter logic [2:0] IRQ_LEVEL    = 3'd4,
  parameter bit         IRQ_ON_WRITE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68kp_latch0_cs,
  input  logic        m68kp_latch1_cs,
  input  logic        m68kp_as_n,
  input  logic        m68kp_rw,
  input  logic        m68kp_uds_n,
  input  logic        m68kp_lds_n,
  input  logic [15:0] m68kp_din,
  output logic [15:0] m68kp_latch_dout,
  input  logic        m68ks_latch0_cs,
  input  logic        m68ks_latch1_cs,
  input  logic        m68ks_as_n,
  input  logic        m68ks_rw,
  input  logic        m68ks_uds_n,
  input  logic        m68ks_lds_n,
  input  logic [15:0] m68ks_din,
  output logic [15:0] m68ks_latch_dout,
  input  logic        m68ks_iack,
  input  logic [2:0]  m68ks_iack_lvl,
  output logic [2:0]  m68ks_ipl_n,
  output logic        latch0_full,
  output logic        latch1_full
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [15:0] latch0;
  logic [15:0] latch1;
  logic [0:0]  irq_state;
  logic [0:0]  irq_state_nxt;

  logic p_wr0_prev, p_rd1_prev, s_wr1_prev, s_rd0_prev, iack_prev;

  logic p_wr0, p_rd1, s_wr1, s_rd0;
  logic p_wr0_commit, p_rd1_start, s_wr1_commit, s_rd0_start, iack_match;

  // Only the legal directions are decoded; wrong-direction writes fall out naturally.
  assign p_wr0 = m68kp_latch0_cs & ~m68kp_as_n & ~m68kp_rw & (~m68kp_uds_n | ~m68kp_lds_n);
  assign p_rd1 = m68kp_latch1_cs & ~m68kp_as_n &  m68kp_rw;
  assign s_wr1 = m68ks_latch1_cs & ~m68ks_as_n & ~m68ks_rw & (~m68ks_uds_n | ~m68ks_lds_n);
  assign s_rd0 = m68ks_latch0_cs & ~m68ks_as_n &  m68ks_rw;

  assign p_wr0_commit = p_wr0 & ~p_wr0_prev;
  assign p_rd1_start  = p_rd1 & ~p_rd1_prev;
  assign s_wr1_commit = s_wr1 & ~s_wr1_prev;
  assign s_rd0_start  = s_rd0 & ~s_rd0_prev;
  assign iack_match   = m68ks_iack & ~iack_prev & (m68ks_iack_lvl == IRQ_LEVEL);

  // A new command outranks a simultaneous acknowledge so it is never lost.
  always_comb begin
    irq_state_nxt = irq_state;
    if (p_wr0_commit && IRQ_ON_WRITE) begin
      irq_state_nxt = ST_PEND;
    end else if (irq_state == ST_PEND && iack_match) begin
      irq_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch0           <= 16'h0000;
      latch1           <= 16'h0000;
      m68kp_latch_dout <= 16'h0000;
      m68ks_latch_dout <= 16'h0000;
      latch0_full      <= 1'b0;
      latch1_full      <= 1'b0;
      irq_state        <= ST_IDLE;
      m68ks_ipl_n      <= 3'b111;
      p_wr0_prev       <= 1'b0;
      p_rd1_prev       <= 1'b0;
      s_wr1_prev       <= 1'b0;
      s_rd0_prev       <= 1'b0;
      iack_prev        <= 1'b0;
    end else begin
      p_wr0_prev <= p_wr0;
      p_rd1_prev <= p_rd1;
      s_wr1_prev <= s_wr1;
      s_rd0_prev <= s_rd0;
      iack_prev  <= m68ks_iack;

      if (p_wr0_commit) begin
        if (!m68kp_uds_n) latch0[15:8] <= m68kp_din[15:8];
        if (!m68kp_lds_n) latch0[7:0]  <= m68kp_din[7:0];
      end
      if (s_wr1_commit) begin
        if (!m68ks_uds_n) latch1[15:8] <= m68ks_din[15:8];
        if (!m68ks_lds_n) latch1[7:0]  <= m68ks_din[7:0];
      end

      // Snapshots take the pre-write value when a write lands in the same clock.
      if (s_rd0_start) m68ks_latch_dout <= latch0;
      if (p_rd1_start) m68kp_latch_dout <= latch1;

      if (p_wr0_commit)     latch0_full <= 1'b1;
      else if (s_rd0_start) latch0_full <= 1'b0;
      if (s_wr1_commit)     latch1_full <= 1'b1;
      else if (p_rd1_start) latch1_full <= 1'b0;

      irq_state   <= irq_state_nxt;
      m68ks_ipl_n <= (irq_state_nxt == ST_PEND) ? ~IRQ_LEVEL : 3'b111;
    end
  end

endmodule

// File: tb/tb_sound_latch_if.sv
// tb/tb_sound_latch_if.sv - scoreboard bench for sound_latch_if with a transaction-level mailbox model
module tb_sound_latch_if;
  logic        clk = 1'b0;
  logic        reset;
  logic        p_cs0, p_cs1, p_as_n, p_rw, p_uds_n, p_lds_n;
  logic [15:0] p_din, p_dout;
  logic        s_cs0, s_cs1, s_as_n, s_rw, s_uds_n, s_lds_n;
  logic [15:0] s_din, s_dout;
  logic        iack;
  logic [2:0]  iack_lvl, ipl_n;
  logic        full0, full1;

  sound_latch_if dut (
    .clk(clk), .reset(reset),
    .m68kp_latch0_cs(p_cs0), .m68kp_latch1_cs(p_cs1), .m68kp_as_n(p_as_n), .m68kp_rw(p_rw),
    .m68kp_uds_n(p_uds_n), .m68kp_lds_n(p_lds_n), .m68kp_din(p_din), .m68kp_latch_dout(p_dout),
    .m68ks_latch0_cs(s_cs0), .m68ks_latch1_cs(s_cs1), .m68ks_as_n(s_as_n), .m68ks_rw(s_rw),
    .m68ks_uds_n(s_uds_n), .m68ks_lds_n(s_lds_n), .m68ks_din(s_din), .m68ks_latch_dout(s_dout),
    .m68ks_iack(iack), .m68ks_iack_lvl(iack_lvl), .m68ks_ipl_n(ipl_n),
    .latch0_full(full0), .latch1_full(full1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mailbox contents, flags, IRQ pending and previous strobe levels.
  logic [15:0] m_l0, m_l1, m_dp, m_ds;
  logic        m_f0, m_f1, m_pend;
  logic        h_pw0, h_pr1, h_sw1, h_sr0, h_ia;

  function automatic logic [15:0] actual(int sel);
    case (sel)
      0:       return p_dout;
      1:       return s_dout;
      2:       return {15'd0, full0};
      3:       return {15'd0, full1};
      default: return {13'd0, ipl_n};
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      0:       return "main_dout";
      1:       return "sound_dout";
      2:       return "latch0_full";
      3:       return "latch1_full";
      default: return "ipl_n";
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [15:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", sel_name(e.sel), cyc, a, e.val);
      end
    end
  end

  task automatic push(int sel, logic [15:0] v);
    exp_t e;
    e.due = cyc + 1;
    e.sel = sel;
    e.val = v;
    q.push_back(e);
  endtask

  // Applies the currently driven inputs to the model for one clock and queues the outcome.
  task automatic tick();
    logic pw0, pr1, sw1, sr0;
    logic c0, rp, c1, rs, ik;
    pw0 = p_cs0 & ~p_as_n & ~p_rw & (~p_uds_n | ~p_lds_n);
    pr1 = p_cs1 & ~p_as_n & p_rw;
    sw1 = s_cs1 & ~s_as_n & ~s_rw & (~s_uds_n | ~s_lds_n);
    sr0 = s_cs0 & ~s_as_n & s_rw;
    if (reset) begin
      m_l0 = 0; m_l1 = 0; m_dp = 0; m_ds = 0;
      m_f0 = 0; m_f1 = 0; m_pend = 0;
      h_pw0 = 0; h_pr1 = 0; h_sw1 = 0; h_sr0 = 0; h_ia = 0;
    end else begin
      c0 = pw0 & ~h_pw0;
      rp = pr1 & ~h_pr1;
      c1 = sw1 & ~h_sw1;
      rs = sr0 & ~h_sr0;
      ik = iack & ~h_ia & (iack_lvl == 3'd4);
      if (rp) m_dp = m_l1;
      if (rs) m_ds = m_l0;
      if (c0) begin
        if (!p_uds_n) m_l0[15:8] = p_din[15:8];
        if (!p_lds_n) m_l0[7:0]  = p_din[7:0];
      end
      if (c1) begin
        if (!s_uds_n) m_l1[15:8] = s_din[15:8];
        if (!s_lds_n) m_l1[7:0]  = s_din[7:0];
      end
      m_f0   = c0 ? 1'b1 : (rs ? 1'b0 : m_f0);
      m_f1   = c1 ? 1'b1 : (rp ? 1'b0 : m_f1);
      m_pend = c0 ? 1'b1 : (ik ? 1'b0 : m_pend);
      h_pw0 = pw0; h_pr1 = pr1; h_sw1 = sw1; h_sr0 = sr0; h_ia = iack;
    end
    push(0, m_dp);
    push(1, m_ds);
    push(2, {15'd0, m_f0});
    push(3, {15'd0, m_f1});
    push(4, m_pend ? 16'h0003 : 16'h0007);
    @(negedge clk);
  endtask

  // Main ops: 0 idle, 1 write latch0, 2 read latch1, 3 write latch1 (wrong direction).
  task automatic set_p(int op, logic u, logic l, logic [15:0] d);
    p_cs0 = (op == 1); p_cs1 = (op == 2 || op == 3);
    p_as_n = (op == 0); p_rw = !(op == 1 || op == 3);
    p_uds_n = (op == 0) ? 1'b1 : u; p_lds_n = (op == 0) ? 1'b1 : l; p_din = d;
  endtask

  // Sound ops: 0 idle, 1 read latch0, 2 write latch1, 3 write latch0 (wrong direction).
  task automatic set_s(int op, logic u, logic l, logic [15:0] d);
    s_cs0 = (op == 1 || op == 3); s_cs1 = (op == 2);
    s_as_n = (op == 0); s_rw = !(op == 2 || op == 3);
    s_uds_n = (op == 0) ? 1'b1 : u; s_lds_n = (op == 0) ? 1'b1 : l; s_din = d;
  endtask

  task automatic idle();
    set_p(0, 1, 1, 16'h0000);
    set_s(0, 1, 1, 16'h0000);
    iack = 0; iack_lvl = 3'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    tick(); tick();
    push(0, 16'h0000); push(1, 16'h0000); push(4, 16'h0007);
    reset = 1'b0;
    tick();

    // Command write with both strobes, IRQ raise, then sound read.
    set_p(1, 0, 0, 16'hA55A); push(4, 16'h0003); push(2, 16'h0001); tick();
    idle(); tick();
    set_s(1, 0, 0, 16'h0000); tick();
    push(1, 16'hA55A); push(2, 16'h0000); idle(); tick();

    // Wrong-level acknowledge ignored, matching one clears.
    iack = 1; iack_lvl = 3'd3; push(4, 16'h0003); tick();
    idle(); tick();
    iack = 1; iack_lvl = 3'd4; push(4, 16'h0007); tick();
    idle(); tick();

    // Write held for 6 clocks commits once: a read and an iack mid-cycle stay effective.
    set_p(1, 0, 0, 16'h5A5A); tick(); tick();
    set_s(1, 0, 0, 16'h0000); tick();
    set_s(0, 1, 1, 16'h0000); iack = 1; iack_lvl = 3'd4; tick();
    push(2, 16'h0000); push(4, 16'h0007); tick(); tick();
    idle(); tick();

    // Byte lanes.
    set_p(1, 0, 0, 16'h1234); tick(); idle(); tick();
    set_p(1, 1, 0, 16'h77CD); tick(); idle(); tick();
    set_p(1, 0, 1, 16'hEF77); tick(); idle(); tick();
    set_s(1, 0, 0, 16'h0000); tick();
    push(1, 16'hEFCD); idle(); tick();

    // Reply written in the same clock as a main read start.
    set_s(2, 0, 0, 16'h0011); tick(); idle(); tick();
    set_p(2, 0, 0, 16'h0000); tick(); idle(); tick();
    set_s(2, 0, 0, 16'h00FF); set_p(2, 0, 0, 16'h0000); tick();
    push(0, 16'h0011); push(3, 16'h0001); idle(); tick();
    set_p(2, 0, 0, 16'h0000); tick();
    push(0, 16'h00FF); push(3, 16'h0000); idle(); tick();

    // Reset while PEND with a write in flight.
    set_p(1, 0, 0, 16'hBEEF); tick(); idle(); tick();
    set_p(1, 0, 0, 16'hC0DE); set_s(2, 0, 0, 16'h4321); reset = 1'b1;
    push(4, 16'h0007); push(2, 16'h0000); push(3, 16'h0000); tick(); tick();
    reset = 1'b0; idle(); tick();
    set_s(1, 0, 0, 16'h0000); set_p(2, 0, 0, 16'h0000); tick();
    push(0, 16'h0000); push(1, 16'h0000); idle(); tick();

    // Randomized concurrent traffic.
    for (int n = 0; n < 400; n++) begin
      int hold;
      set_p($urandom_range(0, 3), 1'($urandom), 1'($urandom), 16'($urandom));
      set_s($urandom_range(0, 3), 1'($urandom), 1'($urandom), 16'($urandom));
      iack = ($urandom_range(0, 3) == 0);
      iack_lvl = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'($urandom);
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) tick();
      idle(); tick();
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
